// File: rtl/m68k_bus_master.sv
// m68k_bus_master: single-byte 68008-style bus cycle master.
// A request presented while idle is latched and run through the sequence
// ADDR -> ASSERT -> (WDS, writes only) -> WAIT -> DATA -> END, one bus
// state per "tick" of CLKDIV sysclk cycles. WAIT lasts until the
// synchronized DTACK is seen at a tick end, or until TIMEOUT ticks have
// elapsed, in which case the cycle ends with a bus error.
//
// Ports
//   sysclk, rst                       clock, async active-high reset
//   req, req_rw, req_addr, req_fc,    request handshake and cycle fields
//   req_wdata                         (req_rw: 1=read, 0=write)
//   busy, done, berr, rdata           status, completion pulse, last read byte
//   addr_bus, fc, rw_, as_, ds_,      bus drive and address-group enable
//   addr_oe
//   data_out, data_oe                 write data drive and enable
//   data_in, dtack_                   responder data and async active-low DTACK
module m68k_bus_master #(
    parameter int ADDRLEN = 20,
    parameter int CLKDIV  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               req,
    input  logic               req_rw,
    input  logic [ADDRLEN-1:0] req_addr,
    input  logic [2:0]         req_fc,
    input  logic [7:0]         req_wdata,
    output logic               busy,
    output logic               done,
    output logic               berr,
    output logic [7:0]         rdata,
    output logic [ADDRLEN-1:0] addr_bus,
    output logic [2:0]         fc,
    output logic               rw_,
    output logic               as_,
    output logic               ds_,
    output logic               addr_oe,
    output logic [7:0]         data_out,
    output logic               data_oe,
    input  logic [7:0]         data_in,
    input  logic               dtack_
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_DATA, S_END
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         tick_q, tick_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic               berr_flag_q, berr_flag_d;
    logic               rd_q, rd_d;
    logic [ADDRLEN-1:0] lat_addr_q, lat_addr_d;
    logic [2:0]         lat_fc_q, lat_fc_d;
    logic [7:0]         lat_wdata_q, lat_wdata_d;
    logic               dtack_s1_q, dtack_s2_q;

    logic               busy_q, busy_d, done_q, done_d, berr_q, berr_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [ADDRLEN-1:0] addr_bus_q, addr_bus_d;
    logic [2:0]         fc_q, fc_d;
    logic               rw_q, rw_d, as_q, as_d, ds_q, ds_d;
    logic               addr_oe_q, addr_oe_d, data_oe_q, data_oe_d;
    logic [7:0]         data_out_q, data_out_d;

    logic               tick_end;

    assign tick_end = (tick_q == 6'(CLKDIV - 1));

    // dtack_ is asynchronous to sysclk: two-flop synchronizer, idles high.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            dtack_s1_q <= 1'b1;
            dtack_s2_q <= 1'b1;
        end else begin
            dtack_s1_q <= dtack_;
            dtack_s2_q <= dtack_s1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_end ? 6'd0 : 6'(tick_q + 6'd1);
        wcnt_d      = wcnt_q;
        berr_flag_d = berr_flag_q;
        rd_d        = rd_q;
        lat_addr_d  = lat_addr_q;
        lat_fc_d    = lat_fc_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        berr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = 6'd0;
                if (req) begin
                    rd_d        = req_rw;
                    lat_addr_d  = req_addr;
                    lat_fc_d    = req_fc;
                    lat_wdata_d = req_wdata;
                    wcnt_d      = '0;
                    berr_flag_d = 1'b0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR:   if (tick_end) state_d = S_ASSERT;
            S_ASSERT: if (tick_end) state_d = rd_q ? S_WAIT : S_WDS;
            S_WDS:    if (tick_end) state_d = S_WAIT;
            S_WAIT: begin
                if (tick_end) begin
                    if (!dtack_s2_q) begin
                        state_d = S_DATA;
                    end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                        // This tick end completes the TIMEOUT-th waiting tick.
                        wcnt_d      = wcnt_q + 1'b1;
                        berr_flag_d = 1'b1;
                        state_d     = S_END;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick_end) begin
                    if (rd_q) rdata_d = data_in;
                    state_d = S_END;
                end
            end
            S_END: begin
                if (tick_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    berr_d  = berr_flag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register.
        busy_d     = (state_d != S_IDLE);
        addr_oe_d  = busy_d;
        addr_bus_d = addr_oe_d ? lat_addr_d : '0;
        fc_d       = addr_oe_d ? lat_fc_d : 3'd0;
        rw_d       = addr_oe_d ? rd_d : 1'b1;
        data_oe_d  = addr_oe_d && !rd_d;
        data_out_d = data_oe_d ? lat_wdata_d : 8'd0;
        as_d       = !(state_d inside {S_ASSERT, S_WDS, S_WAIT, S_DATA});
        ds_d       = !((state_d == S_ASSERT && rd_d) ||
                       (state_d inside {S_WDS, S_WAIT, S_DATA}));
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= 6'd0;
            wcnt_q      <= '0;
            berr_flag_q <= 1'b0;
            rd_q        <= 1'b1;
            lat_addr_q  <= '0;
            lat_fc_q    <= 3'd0;
            lat_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            berr_q      <= 1'b0;
            rdata_q     <= 8'd0;
            addr_bus_q  <= '0;
            fc_q        <= 3'd0;
            rw_q        <= 1'b1;
            as_q        <= 1'b1;
            ds_q        <= 1'b1;
            addr_oe_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            data_out_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            wcnt_q      <= wcnt_d;
            berr_flag_q <= berr_flag_d;
            rd_q        <= rd_d;
            lat_addr_q  <= lat_addr_d;
            lat_fc_q    <= lat_fc_d;
            lat_wdata_q <= lat_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            berr_q      <= berr_d;
            rdata_q     <= rdata_d;
            addr_bus_q  <= addr_bus_d;
            fc_q        <= fc_d;
            rw_q        <= rw_d;
            as_q        <= as_d;
            ds_q        <= ds_d;
            addr_oe_q   <= addr_oe_d;
            data_oe_q   <= data_oe_d;
            data_out_q  <= data_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign berr     = berr_q;
    assign rdata    = rdata_q;
    assign addr_bus = addr_bus_q;
    assign fc       = fc_q;
    assign rw_      = rw_q;
    assign as_      = as_q;
    assign ds_      = ds_q;
    assign addr_oe  = addr_oe_q;
    assign data_oe  = data_oe_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master with CLKDIV=2. u_dut (TIMEOUT=16)
// carries the normal, delayed-DTACK, reset and back-to-back cases; u_to
// (TIMEOUT=4) carries the bus-error case on its own req/dtack_ pins.
module tb_m68k_bus_master;

    logic        sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        rst, req, req_to, req_rw;
    logic [19:0] req_addr;
    logic [2:0]  req_fc;
    logic [7:0]  req_wdata, data_in;
    logic        dtack_, dtack_to_;

    logic        busy, done, berr, rw_, as_, ds_, addr_oe, data_oe;
    logic [7:0]  rdata, data_out;
    logic [19:0] addr_bus;
    logic [2:0]  fc;

    logic        busy_t, done_t, berr_t, rw_t, as_t, ds_t, addr_oe_t, data_oe_t;
    logic [7:0]  rdata_t, data_out_t;
    logic [19:0] addr_bus_t;
    logic [2:0]  fc_t;

    m68k_bus_master #(.ADDRLEN(20), .CLKDIV(2), .TIMEOUT(16)) u_dut (
        .sysclk(sysclk), .rst(rst), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_fc(req_fc), .req_wdata(req_wdata),
        .busy(busy), .done(done), .berr(berr), .rdata(rdata),
        .addr_bus(addr_bus), .fc(fc), .rw_(rw_), .as_(as_), .ds_(ds_),
        .addr_oe(addr_oe), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in), .dtack_(dtack_)
    );

    m68k_bus_master #(.ADDRLEN(20), .CLKDIV(2), .TIMEOUT(4)) u_to (
        .sysclk(sysclk), .rst(rst), .req(req_to), .req_rw(req_rw),
        .req_addr(req_addr), .req_fc(req_fc), .req_wdata(req_wdata),
        .busy(busy_t), .done(done_t), .berr(berr_t), .rdata(rdata_t),
        .addr_bus(addr_bus_t), .fc(fc_t), .rw_(rw_t), .as_(as_t), .ds_(ds_t),
        .addr_oe(addr_oe_t), .data_out(data_out_t), .data_oe(data_oe_t),
        .data_in(data_in), .dtack_(dtack_to_)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle observations gathered while waiting for done on u_dut.
    int          lat, as_lo, ds_lo, first_as, first_ds, oe_bad, proto_bad;
    logic [19:0] addr_s;
    logic [2:0]  fc_s;
    logic        rw_s, cur_write;

    // Issue one request: fields and req set just after an edge, so the next
    // edge is the accepting edge; returns #1 after that edge.
    task automatic start(input bit to, input logic rw, input logic [19:0] a,
                         input logic [2:0] f, input logic [7:0] wd);
        @(posedge sysclk); #1;
        req_rw = rw; req_addr = a; req_fc = f; req_wdata = wd;
        if (to) req_to = 1'b1; else req = 1'b1;
        @(posedge sysclk); #1;
        req = 1'b0; req_to = 1'b0;
        cur_write = !rw;
    endtask

    // lat counts edges after the accepting edge until done is seen.
    task automatic wait_done(input int limit);
        lat = 0; as_lo = 0; ds_lo = 0; first_as = -1; first_ds = -1;
        oe_bad = 0; proto_bad = 0;
        addr_s = addr_bus; fc_s = fc; rw_s = rw_;
        while (!done && lat < limit) begin
            if (!as_) begin as_lo++; if (first_as < 0) first_as = lat; end
            if (!ds_) begin ds_lo++; if (first_ds < 0) first_ds = lat; end
            if ((!as_ && !addr_oe) || (!ds_ && as_)) proto_bad++;
            if (data_oe !== cur_write || (cur_write && data_out !== req_wdata)) oe_bad++;
            @(posedge sysclk); #1;
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_done_to(input int limit);
        lat = 0;
        while (!done_t && lat < limit) begin
            @(posedge sysclk); #1;
            lat++;
        end
        check("done_t_seen", {31'd0, done_t}, 32'd1);
    endtask

    // {busy,done,berr,rw_,as_,ds_,addr_oe,data_oe} expected after reset.
    localparam logic [7:0] RST_CTL = 8'b0001_1100;

    int n_done, first_done, last_done, idle_cycles;

    initial begin
        rst = 1'b1; req = 1'b0; req_to = 1'b0; req_rw = 1'b1;
        req_addr = '0; req_fc = '0; req_wdata = '0; data_in = '0;
        dtack_ = 1'b0; dtack_to_ = 1'b0; cur_write = 1'b0;

        repeat (3) @(posedge sysclk); #1;
        check("rst_ctl", {24'd0, busy, done, berr, rw_, as_, ds_, addr_oe, data_oe}, {24'd0, RST_CTL});
        check("rst_data", {addr_bus, fc, data_out, 1'b0}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        rst = 1'b0;

        // Read, dtack_ tied low: 5 ticks = 10 cycles, as_/ds_ low 3 ticks.
        data_in = 8'hA5;
        start(1'b0, 1'b1, 20'h00123, 3'd5, 8'h00);
        check("rd_busy", {31'd0, busy}, 32'd1);
        wait_done(60);
        check("rd_lat", lat, 10);
        check("rd_as_lo", as_lo, 6);
        check("rd_ds_lo", ds_lo, 6);
        check("rd_addr", {12'd0, addr_s}, 32'h00123);
        check("rd_fc_rw", {28'd0, fc_s, rw_s}, {28'd0, 3'd5, 1'b1});
        check("rd_rdata", {24'd0, rdata}, 32'hA5);
        check("rd_berr", {31'd0, berr}, 32'd0);
        check("rd_busy_done", {31'd0, busy}, 32'd0);
        check("rd_proto", proto_bad, 0);
        check("rd_oe", oe_bad, 0);
        @(posedge sysclk); #1;
        check("rd_done_pulse", {31'd0, done}, 32'd0);

        // Write: 6 ticks = 12 cycles, ds_ falls one tick (2 cycles) after as_.
        start(1'b0, 1'b0, 20'h80034, 3'd1, 8'h3C);
        wait_done(60);
        check("wr_lat", lat, 12);
        check("wr_as_lo", as_lo, 8);
        check("wr_ds_delay", first_ds - first_as, 2);
        check("wr_oe", oe_bad, 0);
        check("wr_rw", {31'd0, rw_s}, 32'd0);
        check("wr_addr", {12'd0, addr_s}, 32'h80034);
        check("wr_berr", {31'd0, berr}, 32'd0);
        check("wr_oe_off", {30'd0, data_oe, addr_oe}, 32'd0);
        check("wr_rdata_kept", {24'd0, rdata}, 32'hA5);
        check("wr_proto", proto_bad, 0);

        // dtack_ goes low 7 ticks after as_ falls (as_ low from cycle 2, so
        // dtack_ low at cycle 16). Synchronized low after edge 18, seen at
        // the tick end at edge 20 -> DATA 20..22, END 22..24, done at 24.
        dtack_ = 1'b1; data_in = 8'h69;
        repeat (3) @(posedge sysclk);
        start(1'b0, 1'b1, 20'h0ABCD, 3'd6, 8'h00);
        fork
            begin repeat (16) @(posedge sysclk); #1; dtack_ = 1'b0; end
        join_none
        wait_done(80);
        check("dly_lat", lat, 24);
        check("dly_rdata", {24'd0, rdata}, 32'h69);
        check("dly_berr", {31'd0, berr}, 32'd0);
        check("dly_proto", proto_bad, 0);

        // u_to: a good read first, then a timed-out one. ADDR+ASSERT+4 WAIT
        // ticks+END = 7 ticks = 14 cycles, rdata stays at the earlier byte.
        data_in = 8'h5A;
        start(1'b1, 1'b1, 20'h00010, 3'd2, 8'h00);
        wait_done_to(60);
        check("to_pre_rdata", {24'd0, rdata_t}, 32'h5A);
        check("to_pre_berr", {31'd0, berr_t}, 32'd0);
        dtack_to_ = 1'b1; data_in = 8'hEE;
        repeat (3) @(posedge sysclk);
        start(1'b1, 1'b1, 20'h00020, 3'd2, 8'h00);
        wait_done_to(60);
        check("to_lat", lat, 14);
        check("to_berr", {31'd0, berr_t}, 32'd1);
        check("to_rdata", {24'd0, rdata_t}, 32'h5A);
        check("to_strobes", {30'd0, as_t, ds_t}, 32'd3);
        check("to_busy", {31'd0, busy_t}, 32'd0);
        @(posedge sysclk); #1;
        check("to_berr_pulse", {31'd0, berr_t}, 32'd0);

        // Reset in WAIT: dtack_ held high, rst at lat 5 (WAIT), checked 1 ns later.
        dtack_ = 1'b1;
        repeat (3) @(posedge sysclk);
        start(1'b0, 1'b1, 20'h00555, 3'd3, 8'h00);
        repeat (5) @(posedge sysclk); #1;
        check("pre_rst_as", {31'd0, as_}, 32'd0);
        rst = 1'b1; #1;
        check("mid_rst_ctl", {24'd0, busy, done, berr, rw_, as_, ds_, addr_oe, data_oe}, {24'd0, RST_CTL});
        check("mid_rst_data", {addr_bus, fc, data_out, 1'b0}, 32'd0);
        check("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        @(posedge sysclk); #1;
        rst = 1'b0; dtack_ = 1'b0; n_done = 0;
        repeat (6) begin @(posedge sysclk); #1; if (done) n_done++; end
        check("rst_no_done", n_done, 0);
        data_in = 8'h11;
        start(1'b0, 1'b1, 20'h00777, 3'd4, 8'h00);
        wait_done(60);
        check("post_rst_lat", lat, 10);
        check("post_rst_rdata", {24'd0, rdata}, 32'h11);

        // req held high: accept every 11 cycles (10 latency + done cycle),
        // dones at 11, 22, 33 edges after req rises; busy low only then.
        data_in = 8'h77; req_rw = 1'b1; req_addr = 20'h00100; req_fc = 3'd1;
        @(posedge sysclk); #1;
        req = 1'b1;
        n_done = 0; first_done = -1; last_done = -1; idle_cycles = 0;
        for (int n = 1; n <= 34; n++) begin
            @(posedge sysclk); #1;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = n;
                last_done = n;
            end
            if (!busy) idle_cycles++;
        end
        req = 1'b0;
        check("b2b_count", n_done, 3);
        check("b2b_first", first_done, 11);
        check("b2b_last", last_done, 33);
        check("b2b_idle", idle_cycles, 3);
        check("b2b_rdata", {24'd0, rdata}, 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
